mac_lb_traffic: RTL and testbench

MAC_LB_TRAFFIC -- requirements
Module: mac_lb_traffic

---
 rtl/mac_lb_pkg.sv | 26 ++
 rtl/mac_lb_traffic_if.sv | 18 +
 rtl/mac_lb_checker.sv | 86 ++++++++
 rtl/mac_lb_traffic.sv | 181 ++++++++++++++++++
 tb/tb_mac_lb_traffic.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_lb_pkg.sv
// Shared definitions for the MAC loopback traffic generator/checker.
//   DATA_W / KEEP_W : AXI-Stream data and keep widths (64-bit datapath)
//   tx_state_e      : TX FSM state encoding
//   pack_beat()     : builds the self-describing beat word
//                     {seq, beat, ~seq, ~beat}
package mac_lb_pkg;

    localparam int DATA_W = 64;
    localparam int KEEP_W = DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } tx_state_e;

    // The inverted copies let the checker catch stuck or flipped bits in
    // both halves of the word, not just a wrong sequence number.
    function automatic logic [DATA_W-1:0] pack_beat(input logic [15:0] seq,
                                                    input logic [15:0] beat);
        return {seq, beat, ~seq, ~beat};
    endfunction

endpackage

// File: rtl/mac_lb_traffic_if.sv
// AXI-Stream bundle between the traffic block and the MAC.
//   master : drives tdata/tkeep/tvalid/tlast, samples tready
//   slave  : samples tdata/tkeep/tvalid/tlast, drives tready
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both 1; while tvalid=1 and tready=0 the master holds tdata/tkeep/tlast.
interface mac_lb_traffic_if;
    import mac_lb_pkg::*;

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);

endinterface

// File: rtl/mac_lb_checker.sv
// RX loopback checker: compares every received beat against the expected
// {eseq, ebeat, ~eseq, ~ebeat} word and counts good/bad frames.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr          : clears expected position and counters (accepted start)
//   beats        : beats per frame (already forced to >= 1)
//   rx           : AXIS slave from the MAC RX path, tready tied high
//   rx_good      : saturating count of clean frames
//   rx_err       : saturating count of bad frames
module mac_lb_checker (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic [7:0]              beats,
    mac_lb_traffic_if.slave         rx,
    output logic [15:0]             rx_good,
    output logic [15:0]             rx_err
);
    import mac_lb_pkg::*;

    logic [15:0]       eseq_q, eseq_d;
    logic [7:0]        ebeat_q, ebeat_d;
    logic              bad_q, bad_d;
    logic [15:0]       good_q, good_d;
    logic [15:0]       err_q, err_d;
    logic [DATA_W-1:0] exp_word;
    logic              at_end;
    logic              frame_bad;

    // The MAC RX path cannot be stalled.
    assign rx.tready = 1'b1;

    always_comb begin
        eseq_d    = eseq_q;
        ebeat_d   = ebeat_q;
        bad_d     = bad_q;
        good_d    = good_q;
        err_d     = err_q;
        exp_word  = pack_beat(eseq_q, {8'h00, ebeat_q});
        at_end    = (ebeat_q == beats - 8'd1);
        // A beat past the expected length without tlast also spoils the frame.
        frame_bad = bad_q || (rx.tdata != exp_word) || (rx.tkeep != '1) ||
                    (at_end && !rx.tlast);
        if (clr) begin
            eseq_d  = '0;
            ebeat_d = '0;
            bad_d   = 1'b0;
            good_d  = '0;
            err_d   = '0;
        end else if (rx.tvalid) begin
            if (rx.tlast) begin
                if (frame_bad || !at_end) begin
                    if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                end else begin
                    if (good_q != 16'hFFFF) good_d = good_q + 16'd1;
                end
                ebeat_d = '0;
                bad_d   = 1'b0;
                // Resync on the received sequence so one bad frame costs one count.
                eseq_d  = rx.tdata[63:48] + 16'd1;
            end else begin
                bad_d = frame_bad;
                if (!at_end) ebeat_d = ebeat_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eseq_q  <= '0;
            ebeat_q <= '0;
            bad_q   <= 1'b0;
            good_q  <= '0;
            err_q   <= '0;
        end else begin
            eseq_q  <= eseq_d;
            ebeat_q <= ebeat_d;
            bad_q   <= bad_d;
            good_q  <= good_d;
            err_q   <= err_d;
        end
    end

    assign rx_good = good_q;
    assign rx_err  = err_q;

endmodule

// File: rtl/mac_lb_traffic.sv
// MAC loopback traffic generator: sends cfg_frames frames of cfg_beats beats
// of patterned data to the MAC TX, and checks the looped-back RX stream.
//   clk, rst_n            : MAC user clock, asynchronous active-low reset
//   mac_ready             : link up; a new frame starts only while high
//   start                 : one-cycle pulse, accepted only in IDLE
//   cfg_frames, cfg_beats : run length (beats 0 is treated as 1)
//   tx                    : AXIS master to MAC TX
//   rx                    : AXIS slave from MAC RX
//   busy, done            : run in progress / sticky completion
//   tx_frames, rx_good, rx_err : saturating frame counters
//   dbg_state             : current TX FSM state
module mac_lb_traffic #(
    parameter int IFG_CYCLES = 4,
    parameter int DATA_W     = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mac_ready,
    input  logic                  start,
    input  logic [15:0]           cfg_frames,
    input  logic [7:0]            cfg_beats,
    mac_lb_traffic_if.master      tx,
    mac_lb_traffic_if.slave       rx,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           tx_frames,
    output logic [15:0]           rx_good,
    output logic [15:0]           rx_err,
    output mac_lb_pkg::tx_state_e dbg_state
);
    import mac_lb_pkg::*;

    tx_state_e         state_q, state_d;
    logic [15:0]       frames_left_q, frames_left_d;
    logic [7:0]        beats_q, beats_d;
    logic [15:0]       seq_q, seq_d;
    logic [7:0]        beat_q, beat_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;
    logic [15:0]       tx_frames_q, tx_frames_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic [KEEP_W-1:0] tkeep_q, tkeep_d;
    logic [7:0]        next_beat;
    logic              accept_start;

    assign accept_start = start && (state_q == ST_IDLE);

    always_comb begin
        state_d       = state_q;
        frames_left_d = frames_left_q;
        beats_d       = beats_q;
        seq_d         = seq_q;
        beat_d        = beat_q;
        gap_cnt_d     = gap_cnt_q;
        tx_frames_d   = tx_frames_q;
        busy_d        = busy_q;
        done_d        = done_q;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        tdata_d       = tdata_q;
        tkeep_d       = tkeep_q;
        next_beat     = beat_q + 8'd1;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_WAIT_RDY;
                    frames_left_d = cfg_frames;
                    beats_d       = (cfg_beats == 8'd0) ? 8'd1 : cfg_beats;
                    seq_d         = '0;
                    beat_d        = '0;
                    tx_frames_d   = '0;
                    done_d        = 1'b0;
                    busy_d        = 1'b1;
                end
            end
            ST_WAIT_RDY: begin
                if (frames_left_q == 16'd0) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                end else if (mac_ready) begin
                    // First beat is loaded here so tvalid rises on the next edge.
                    state_d  = ST_SEND;
                    beat_d   = '0;
                    tvalid_d = 1'b1;
                    tkeep_d  = '1;
                    tdata_d  = pack_beat(seq_q, 16'h0000);
                    tlast_d  = (beats_q == 8'd1);
                end
            end
            ST_SEND: begin
                // mac_ready is deliberately ignored here: a started frame always completes.
                if (tx.tready) begin
                    if (tlast_q) begin
                        tvalid_d      = 1'b0;
                        tlast_d       = 1'b0;
                        tkeep_d       = '0;
                        beat_d        = '0;
                        seq_d         = seq_q + 16'd1;
                        frames_left_d = frames_left_q - 16'd1;
                        if (tx_frames_q != 16'hFFFF) tx_frames_d = tx_frames_q + 16'd1;
                        if (IFG_CYCLES > 0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = '0;
                        end else begin
                            state_d = ST_WAIT_RDY;
                        end
                    end else begin
                        beat_d  = next_beat;
                        tdata_d = pack_beat(seq_q, {8'h00, next_beat});
                        tlast_d = (next_beat == beats_q - 8'd1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 8'(IFG_CYCLES - 1)) state_d = ST_WAIT_RDY;
                else gap_cnt_d = gap_cnt_q + 8'd1;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            frames_left_q <= '0;
            beats_q       <= 8'd1;
            seq_q         <= '0;
            beat_q        <= '0;
            gap_cnt_q     <= '0;
            tx_frames_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            tdata_q       <= '0;
            tkeep_q       <= '0;
        end else begin
            state_q       <= state_d;
            frames_left_q <= frames_left_d;
            beats_q       <= beats_d;
            seq_q         <= seq_d;
            beat_q        <= beat_d;
            gap_cnt_q     <= gap_cnt_d;
            tx_frames_q   <= tx_frames_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            tdata_q       <= tdata_d;
            tkeep_q       <= tkeep_d;
        end
    end

    assign tx.tvalid = tvalid_q;
    assign tx.tlast  = tlast_q;
    assign tx.tdata  = tdata_q;
    assign tx.tkeep  = tkeep_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign tx_frames = tx_frames_q;
    assign dbg_state = state_q;

    // The checker uses the latched beat count, valid from the edge that accepts start.
    mac_lb_checker u_checker (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept_start),
        .beats   (beats_q),
        .rx      (rx),
        .rx_good (rx_good),
        .rx_err  (rx_err)
    );

endmodule

// File: tb/tb_mac_lb_traffic.sv
`timescale 1ns/1ps
module tb_mac_lb_traffic;
    import mac_lb_pkg::*;

    // ---------------- clock / reset / signals ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mac_ready = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cfg_frames = '0;
    logic [7:0]  cfg_beats = '0;
    logic        busy, done;
    logic [15:0] tx_frames, rx_good, rx_err;
    tx_state_e   dbg_state;

    always #5 clk = ~clk;

    mac_lb_traffic_if tx_if ();
    mac_lb_traffic_if rx_if ();

    mac_lb_traffic #(.IFG_CYCLES(4), .DATA_W(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mac_ready  (mac_ready),
        .start      (start),
        .cfg_frames (cfg_frames),
        .cfg_beats  (cfg_beats),
        .tx         (tx_if),
        .rx         (rx_if),
        .busy       (busy),
        .done       (done),
        .tx_frames  (tx_frames),
        .rx_good    (rx_good),
        .rx_err     (rx_err),
        .dbg_state  (dbg_state)
    );

    // ---------------- loopback with optional corruption ----------------
    logic corrupt_en = 1'b0;
    logic flip;
    assign flip = corrupt_en && (tx_if.tdata[63:48] == 16'd1) && (tx_if.tdata[47:32] == 16'd2);
    assign rx_if.tvalid = tx_if.tvalid & tx_if.tready;
    assign rx_if.tdata  = tx_if.tdata ^ {63'd0, flip};
    assign rx_if.tkeep  = tx_if.tkeep;
    assign rx_if.tlast  = tx_if.tlast;

    // tready: mode 0 always high, mode 1 toggles every cycle
    int tready_mode = 0;
    always @(posedge clk) begin
        #1;
        if (tready_mode == 1) tx_if.tready = ~tx_if.tready;
        else tx_if.tready = 1'b1;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] exp_word(input int seq, input int beat, input logic last);
        logic [15:0] s;
        logic [15:0] b;
        s = 16'(seq);
        b = 16'(beat);
        return {6'd0, 1'b1, 8'hFF, last, s, b, ~s, ~b};
    endfunction

    // ---------------- scoreboard ----------------
    logic [79:0] exp_q[$];
    int          n_beats = 0;
    int          n_tvalid = 0;
    logic        hold_v = 1'b0;
    logic [79:0] hold_w;
    logic [79:0] cur_w;

    always @(negedge clk) begin
        cur_w = {6'd0, tx_if.tvalid, tx_if.tkeep, tx_if.tlast, tx_if.tdata};
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) chk("tx_stall_hold", cur_w, hold_w);
            hold_v = 1'b0;
            if (tx_if.tvalid) n_tvalid++;
            if (tx_if.tvalid && tx_if.tready) begin
                n_beats++;
                if (exp_q.size() == 0) chk("tx_beat_unexpected", cur_w, 80'd0);
                else chk("tx_beat", cur_w, exp_q.pop_front());
            end else if (tx_if.tvalid) begin
                hold_v = 1'b1;
                hold_w = cur_w;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_run(input int frames, input int beats);
        int eff;
        eff = (beats == 0) ? 1 : beats;
        for (int f = 0; f < frames; f++)
            for (int b = 0; b < eff; b++)
                exp_q.push_back(exp_word(f, b, b == eff - 1));
    endtask

    task automatic run_start(input int frames, input int beats);
        @(posedge clk);
        #1;
        cfg_frames = 16'(frames);
        cfg_beats  = 8'(beats);
        push_run(frames, beats);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i;
        i = 0;
        while (!done && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(tag, done, 1'b1);
    endtask

    task automatic check_counts(input string tag, input int txf, input int good, input int err);
        @(negedge clk);
        chk({tag, "_tx_frames"}, tx_frames, 80'(txf));
        chk({tag, "_rx_good"}, rx_good, 80'(good));
        chk({tag, "_rx_err"}, rx_err, 80'(err));
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_exp_q_empty"}, exp_q.size(), 80'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int i;
        int nb0;
        int nv0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", tx_if.tvalid, 1'b0);
        chk("rst_tlast", tx_if.tlast, 1'b0);
        chk("rst_tdata", tx_if.tdata, 80'd0);
        chk("rst_tkeep", tx_if.tkeep, 80'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_counters", {tx_frames, rx_good, rx_err}, 80'd0);
        chk("rst_rx_tready", rx_if.tready, 1'b1);
        chk("rst_state", dbg_state, ST_IDLE);
        rst_n = 1'b1;
        mac_ready = 1'b1;

        // basic run: 3 frames x 4 beats
        nb0 = n_beats;
        run_start(3, 4);
        wait_done("basic_done", 300);
        chk("basic_beats", n_beats - nb0, 80'd12);
        check_counts("basic", 3, 3, 0);

        // backpressure toggling every cycle
        tready_mode = 1;
        run_start(3, 4);
        wait_done("stall_done", 500);
        check_counts("stall", 3, 3, 0);
        tready_mode = 0;

        // mac_ready low at start, rises 100 cycles later, drops mid-frame
        mac_ready = 1'b0;
        run_start(2, 4);
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("rdy_wait_tvalid", tx_if.tvalid, 1'b0);
        chk("rdy_wait_busy", busy, 1'b1);
        @(posedge clk);
        #1 mac_ready = 1'b1;
        @(negedge clk);
        chk("rdy_tvalid_same_cycle", tx_if.tvalid, 1'b0);
        @(negedge clk);
        chk("rdy_tvalid_next_cycle", tx_if.tvalid, 1'b1);
        @(posedge clk);
        #1 mac_ready = 1'b0;
        i = 0;
        while (tx_frames != 16'd1 && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk("rdy_drop_frame_done", tx_frames, 80'd1);
        nv0 = n_tvalid;
        repeat (20) @(negedge clk);
        chk("rdy_drop_no_tvalid", n_tvalid - nv0, 80'd0);
        chk("rdy_drop_state", dbg_state, ST_WAIT_RDY);
        mac_ready = 1'b1;
        wait_done("rdy_done", 300);
        check_counts("rdy", 2, 2, 0);

        // corrupt bit 0 of frame 1 beat 2 on RX
        corrupt_en = 1'b1;
        run_start(3, 4);
        wait_done("corrupt_done", 300);
        corrupt_en = 1'b0;
        check_counts("corrupt", 3, 2, 1);

        // zero frames
        nv0 = n_tvalid;
        run_start(0, 4);
        i = 0;
        while (!done && i < 10) begin
            @(negedge clk);
            i++;
        end
        chk("zero_frames_done_within_3", (done && i <= 3), 1'b1);
        chk("zero_frames_no_tvalid", n_tvalid - nv0, 80'd0);
        check_counts("zero_frames", 0, 0, 0);

        // zero beats -> single-beat frames
        run_start(2, 0);
        wait_done("zero_beats_done", 200);
        check_counts("zero_beats", 2, 2, 0);

        // reset during frame 1 beat 2
        run_start(3, 4);
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!(tx_if.tvalid && tx_if.tdata[63:48] == 16'd1 && tx_if.tdata[47:32] == 16'd2) && i < 100);
        chk("rst_mid_reached_beat2", tx_if.tdata[47:0], exp_word(1, 2, 1'b0) & 80'hFFFF_FFFF_FFFF);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tvalid", tx_if.tvalid, 1'b0);
        chk("rst_mid_counters", {tx_frames, rx_good, rx_err}, 80'd0);
        chk("rst_mid_busy", busy, 1'b0);
        exp_q.delete();
        #20;
        rst_n = 1'b1;
        nv0 = n_tvalid;
        repeat (20) @(negedge clk);
        chk("rst_mid_no_resume", n_tvalid - nv0, 80'd0);
        chk("rst_mid_state_idle", dbg_state, ST_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
